// File: rtl/hem_ctx_pkg.sv
// Shared types and defaults for the HEM context path.
//   ctx_state_t : context-buffer mode (FILL = no stored frame yet, STREAM = context from memory)
//   DEF_WIDTH   : feature element width, identical to the concat stage
//   DEF_DEPTH   : feature elements per frame
//   ctx_pair_t  : feature/context pair in concat bit order (feature in the MSBs)
package hem_ctx_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 16;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } ctx_state_t;

  // "context" is a reserved word, so the context half is named ctx.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] feature;
    logic [DEF_WIDTH-1:0] ctx;
  } ctx_pair_t;

  function automatic ctx_pair_t make_pair(input logic [DEF_WIDTH-1:0] feature,
                                          input logic [DEF_WIDTH-1:0] ctx);
    ctx_pair_t p;
    p.feature = feature;
    p.ctx     = ctx;
    return p;
  endfunction

endpackage

// File: rtl/temporal_context_buffer_if.sv
// Feature-in / pair-out handshake bundle of the temporal context buffer.
//   in_valid/in_ready/in_feature/in_last        : current-frame feature beats
//   out_valid/out_ready/out_feature/out_context : aligned pair towards concat
//   out_last/ctx_valid                          : pair sideband
// slave = the buffer itself, master = the feeder/consumer environment.
interface temporal_context_buffer_if #(
  parameter int WIDTH = hem_ctx_pkg::DEF_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_feature;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_feature;
  logic [WIDTH-1:0] out_context;
  logic             out_last;
  logic             ctx_valid;

  modport slave (
    input  in_valid, in_feature, in_last, out_ready,
    output in_ready, out_valid, out_feature, out_context, out_last, ctx_valid
  );

  modport master (
    output in_valid, in_feature, in_last, out_ready,
    input  in_ready, out_valid, out_feature, out_context, out_last, ctx_valid
  );
endinterface

// File: rtl/ctx_frame_ram.sv
// Frame memory holding one frame of features.
//   clk   : write clock
//   we    : write enable
//   addr  : shared read/write address
//   wdata : write data
//   rdata : asynchronous read data (returns the pre-write value in the write cycle)
// Storage is not reset; contents after reset are don't-care.
module ctx_frame_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  assign rdata = mem_q[addr];
endmodule

// File: rtl/temporal_context_buffer.sv
// Temporal context buffer: pairs each current-frame feature with the
// co-located feature of the previous frame, writing the current feature
// back in place so that frame N becomes the context of frame N+1.
//   clk, rst    : clock, asynchronous active-high reset
//   ctx_clear   : discard stored context at the next edge (blocks input that cycle)
//   bus         : feature-in / pair-out handshake (slave modport)
//   frame_cnt   : frames completed since reset or clear (wraps)
//   len_err     : sticky frame-length error
//
// state  | meaning
// FILL   | first frame after reset/clear, context is zero-filled
// STREAM | context read from the frame memory
module temporal_context_buffer
  import hem_ctx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int FCW   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ctx_clear,
  temporal_context_buffer_if.slave    bus,
  output logic [FCW-1:0]              frame_cnt,
  output logic                        len_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  ctx_state_t       state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic             len_err_q, len_err_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_feature_q, out_feature_d;
  logic [WIDTH-1:0] out_context_q, out_context_d;
  logic             out_last_q, out_last_d;
  logic             ctx_valid_q, ctx_valid_d;

  logic             in_ready;
  logic             accept;
  logic             at_last;
  logic             frame_end;
  logic [WIDTH-1:0] ram_rdata;

  ctx_frame_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .addr  (addr_q),
    .wdata (bus.in_feature),
    .rdata (ram_rdata)
  );

  always_comb begin
    in_ready  = !ctx_clear && (!out_valid_q || bus.out_ready);
    accept    = bus.in_valid && in_ready;
    at_last   = (addr_q == LAST_ADDR);
    frame_end = accept && (bus.in_last || at_last);
  end

  // Next-state: FSM, address/frame counters, length check, output register.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    frame_cnt_d   = frame_cnt_q;
    len_err_d     = len_err_q;
    out_valid_d   = out_valid_q;
    out_feature_d = out_feature_q;
    out_context_d = out_context_q;
    out_last_d    = out_last_q;
    ctx_valid_d   = ctx_valid_q;

    // ctx_clear forces in_ready low, so it never coincides with an accept.
    if (ctx_clear) begin
      state_d     = FILL;
      addr_d      = '0;
      frame_cnt_d = '0;
    end else if (accept) begin
      if (frame_end) begin
        addr_d      = '0;
        frame_cnt_d = frame_cnt_q + FCW'(1);
        state_d     = STREAM;
      end else begin
        addr_d = addr_q + AW'(1);
      end
    end

    // A frame closed short (last before the final slot) or overrun (no last
    // at the final slot) is flagged but still closed normally.
    if (accept && (bus.in_last != at_last)) len_err_d = 1'b1;

    // The output register continues its handshake even during ctx_clear so a
    // pending pair can drain.
    if (accept) begin
      out_valid_d   = 1'b1;
      out_feature_d = bus.in_feature;
      out_last_d    = bus.in_last;
      ctx_valid_d   = (state_q == STREAM);
      out_context_d = (state_q == STREAM) ? ram_rdata : '0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= FILL;
      addr_q        <= '0;
      frame_cnt_q   <= '0;
      len_err_q     <= 1'b0;
      out_valid_q   <= 1'b0;
      out_feature_q <= '0;
      out_context_q <= '0;
      out_last_q    <= 1'b0;
      ctx_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      frame_cnt_q   <= frame_cnt_d;
      len_err_q     <= len_err_d;
      out_valid_q   <= out_valid_d;
      out_feature_q <= out_feature_d;
      out_context_q <= out_context_d;
      out_last_q    <= out_last_d;
      ctx_valid_q   <= ctx_valid_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_feature = out_feature_q;
  assign bus.out_context = out_context_q;
  assign bus.out_last    = out_last_q;
  assign bus.ctx_valid   = ctx_valid_q;
  assign frame_cnt       = frame_cnt_q;
  assign len_err         = len_err_q;
endmodule

// File: tb/tb_temporal_context_buffer.sv
module tb_temporal_context_buffer;
  localparam int W = 8;
  localparam int D = 4;
  localparam int F = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         ctx_clear;
  logic [F-1:0] frame_cnt;
  logic         len_err;

  temporal_context_buffer_if #(.WIDTH(W)) bus ();

  temporal_context_buffer #(
    .WIDTH (W),
    .DEPTH (D),
    .FCW   (F)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ctx_clear (ctx_clear),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: previous frame as an array, element index within frame.
  logic [W-1:0] prev_frame [D];
  int           elem_idx;
  bit           have_ctx;
  int           frames;
  bit           err_seen;
  bit           exp_ov;
  logic [W-1:0] exp_feat;
  logic [W-1:0] exp_ctx;
  bit           exp_last;
  bit           exp_cv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    elem_idx = 0;
    have_ctx = 0;
    frames   = 0;
    err_seen = 0;
    exp_ov   = 0;
    exp_feat = '0;
    exp_ctx  = '0;
    exp_last = 0;
    exp_cv   = 0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ".out_valid"},   {31'b0, bus.out_valid}, {31'b0, exp_ov});
    chk({where, ".out_feature"}, {24'b0, bus.out_feature}, {24'b0, exp_feat});
    chk({where, ".out_context"}, {24'b0, bus.out_context}, {24'b0, exp_ctx});
    chk({where, ".out_last"},    {31'b0, bus.out_last}, {31'b0, exp_last});
    chk({where, ".ctx_valid"},   {31'b0, bus.ctx_valid}, {31'b0, exp_cv});
    chk({where, ".frame_cnt"},   {24'b0, frame_cnt}, 32'(frames % 256));
    chk({where, ".len_err"},     {31'b0, len_err}, {31'b0, err_seen});
  endtask

  // Called at a negedge: drive, check in_ready, advance one edge, check outputs.
  task automatic cycle(input bit v, input logic [W-1:0] f, input bit l,
                       input bit rdy, input bit clr, input string where);
    bit exp_ir;
    bit acc;
    bus.in_valid   = v;
    bus.in_feature = f;
    bus.in_last    = l;
    bus.out_ready  = rdy;
    ctx_clear      = clr;
    #1;
    exp_ir = !clr && (!exp_ov || rdy);
    chk({where, ".in_ready"}, {31'b0, bus.in_ready}, {31'b0, exp_ir});
    @(posedge clk);
    acc = v && exp_ir;
    if (acc) begin
      exp_ov   = 1;
      exp_feat = f;
      exp_last = l;
      exp_cv   = have_ctx;
      exp_ctx  = have_ctx ? prev_frame[elem_idx] : '0;
      prev_frame[elem_idx] = f;
      if (l != (elem_idx == D - 1)) err_seen = 1;
      if (l || elem_idx == D - 1) begin
        elem_idx = 0;
        frames++;
        have_ctx = 1;
      end else begin
        elem_idx++;
      end
    end else if (exp_ov && rdy) begin
      exp_ov = 0;
    end
    if (clr) begin
      have_ctx = 0;
      elem_idx = 0;
      frames   = 0;
    end
    @(negedge clk);
    check_outputs(where);
  endtask

  initial begin
    logic [W-1:0] f0 [4];
    logic [W-1:0] f1 [4];
    f0 = '{8'hAA, 8'h0F, 8'hFF, 8'h00};
    f1 = '{8'hCC, 8'hF0, 8'h00, 8'h11};

    rst            = 1'b1;
    ctx_clear      = 1'b0;
    bus.in_valid   = 1'b0;
    bus.in_feature = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b0;

    // Frame 0: zero context.
    for (int i = 0; i < 4; i++) cycle(1, f0[i], i == 3, 1, 0, "frame0");
    chk("frame0.cnt_final", {24'b0, frame_cnt}, 32'd1);

    // Frame 1 with backpressure after the 2nd beat.
    cycle(1, f1[0], 0, 1, 0, "frame1");
    chk("frame1.ctx0", {24'b0, bus.out_context}, 32'hAA);
    cycle(1, f1[1], 0, 1, 0, "frame1");
    for (int i = 0; i < 3; i++) cycle(1, f1[2], 0, 0, 0, "stall");
    cycle(1, f1[2], 0, 1, 0, "frame1");
    chk("frame1.ctx2", {24'b0, bus.out_context}, 32'hFF);
    cycle(1, f1[3], 1, 1, 0, "frame1");
    chk("frame1.ctx3", {24'b0, bus.out_context}, 32'h00);
    chk("frame1.cnt_final", {24'b0, frame_cnt}, 32'd2);

    // Short frame: last on the 2nd beat.
    cycle(1, 8'h55, 0, 1, 0, "short");
    chk("short.ctx0", {24'b0, bus.out_context}, 32'hCC);
    cycle(1, 8'h66, 1, 1, 0, "short");
    chk("short.len_err", {31'b0, len_err}, 32'd1);
    cycle(1, 8'h77, 0, 1, 0, "after_short");
    chk("after_short.ctx0", {24'b0, bus.out_context}, 32'h55);

    // Clear mid-frame.
    cycle(1, 8'h88, 0, 1, 0, "frame3");
    cycle(1, 8'h99, 0, 1, 1, "clear");
    chk("clear.frame_cnt", {24'b0, frame_cnt}, 32'd0);
    for (int i = 0; i < 4; i++) cycle(1, 8'(8'h10 + i), i == 3, 1, 0, "post_clear");
    chk("post_clear.len_err_sticky", {31'b0, len_err}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, "rand");

    // Asynchronous reset while a pair is pending.
    cycle(0, 8'h00, 0, 1, 0, "drain");
    cycle(1, 8'h5A, 0, 0, 0, "pend");
    chk("pend.out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle(1, 8'($urandom), i == 3, 1, 0, "post_rst");
    cycle(1, 8'h3C, 0, 1, 0, "post_rst_stream");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
